// File: rtl/wb_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_arb_pkg
// Description : Shared types and constants for the 4-master Wishbone
//               round-robin arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package wb_arb_pkg;

    localparam int N_ARB_MASTERS = 4;
    localparam int GNT_W         = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN   = 2'd1,
        ABORT = 2'd2
    } wb_arb_state_e;

endpackage
`default_nettype wire

// File: rtl/wb_rr_pick4.sv
`default_nettype none
// ============================================================================
// Module      : wb_rr_pick4
// Description : Combinational round-robin picker. Searches the request
//               vector starting one position after the previous winner.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_rr_pick4
    import wb_arb_pkg::*;
(
    input  logic [N_ARB_MASTERS-1:0] req,
    input  logic [GNT_W-1:0]         last,
    output logic [GNT_W-1:0]         idx,
    output logic                     any
);

    logic [GNT_W-1:0] cand;
    logic             found;

    // First requester found walking last+1, last+2, ... (mod 4) wins
    always_comb begin
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int i = 1; i <= N_ARB_MASTERS; i++) begin
            cand = last + GNT_W'(i);
            if (!found && req[cand]) begin
                idx   = cand;
                found = 1'b1;
            end
        end
        any = found;
    end

endmodule
`default_nettype wire

// File: rtl/wb_arbiter_4x1_rr.sv
`default_nettype none
// ============================================================================
// Module      : wb_arbiter_4x1_rr
// Description : Round-robin arbiter sharing one Wishbone slave port between
//               four masters. Ownership is held for a whole CYC; a watchdog
//               aborts a strobe the slave never answers.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_arbiter_4x1_rr
    import wb_arb_pkg::*;
#(
    parameter int WB_ADDR_WIDTH = 32,
    parameter int WB_DATA_WIDTH = 32,
    parameter int TIMEOUT       = 256
) (
    input  logic                                        clk,
    input  logic                                        rstn,
    // Master side, one slice per master (master i at bits [i*W +: W])
    input  logic [N_ARB_MASTERS-1:0]                    m_cyc,
    input  logic [N_ARB_MASTERS-1:0]                    m_stb,
    input  logic [N_ARB_MASTERS-1:0]                    m_we,
    input  logic [N_ARB_MASTERS*WB_ADDR_WIDTH-1:0]      m_adr,
    input  logic [N_ARB_MASTERS*WB_DATA_WIDTH-1:0]      m_dat_w,
    input  logic [N_ARB_MASTERS*(WB_DATA_WIDTH/8)-1:0]  m_sel,
    input  logic [N_ARB_MASTERS*3-1:0]                  m_cti,
    input  logic [N_ARB_MASTERS*2-1:0]                  m_bte,
    output logic [N_ARB_MASTERS-1:0]                    m_ack,
    output logic [N_ARB_MASTERS-1:0]                    m_err,
    output logic [WB_DATA_WIDTH-1:0]                    m_dat_r,
    // Shared slave port
    output logic                                        s0_cyc,
    output logic                                        s0_stb,
    output logic                                        s0_we,
    output logic [WB_ADDR_WIDTH-1:0]                    s0_adr,
    output logic [WB_DATA_WIDTH-1:0]                    s0_dat_w,
    output logic [WB_DATA_WIDTH/8-1:0]                  s0_sel,
    output logic [2:0]                                  s0_cti,
    output logic [1:0]                                  s0_bte,
    input  logic                                        s0_ack,
    input  logic                                        s0_err,
    input  logic [WB_DATA_WIDTH-1:0]                    s0_dat_r,
    // Status
    output logic [GNT_W-1:0]                            gnt,
    output logic                                        gnt_vld,
    output logic                                        timeout_evt
);

    localparam int SEL_W = WB_DATA_WIDTH / 8;
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    // Abort is decided in the cycle whose increment would reach TIMEOUT
    localparam logic [CNT_W-1:0] TMO_M1  = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_SAT = (TIMEOUT > 0) ? CNT_W'(TIMEOUT) : '1;

    wb_arb_state_e    state;
    wb_arb_state_e    state_nxt;
    logic [GNT_W-1:0] last;
    logic [CNT_W-1:0] wd_cnt;
    logic             abort_first;
    logic [GNT_W-1:0] pick_idx;
    logic             pick_any;
    logic             wd_wait;
    logic             wd_expire;

    logic [WB_ADDR_WIDTH-1:0] m_adr_a   [N_ARB_MASTERS];
    logic [WB_DATA_WIDTH-1:0] m_dat_w_a [N_ARB_MASTERS];
    logic [SEL_W-1:0]         m_sel_a   [N_ARB_MASTERS];
    logic [2:0]               m_cti_a   [N_ARB_MASTERS];
    logic [1:0]               m_bte_a   [N_ARB_MASTERS];

    genvar gi;
    generate
        for (gi = 0; gi < N_ARB_MASTERS; gi++) begin : g_split
            assign m_adr_a[gi]   = m_adr[gi*WB_ADDR_WIDTH +: WB_ADDR_WIDTH];
            assign m_dat_w_a[gi] = m_dat_w[gi*WB_DATA_WIDTH +: WB_DATA_WIDTH];
            assign m_sel_a[gi]   = m_sel[gi*SEL_W +: SEL_W];
            assign m_cti_a[gi]   = m_cti[gi*3 +: 3];
            assign m_bte_a[gi]   = m_bte[gi*2 +: 2];
        end
    endgenerate

    wb_rr_pick4 u_pick (
        .req  (m_cyc),
        .last (last),
        .idx  (pick_idx),
        .any  (pick_any)
    );

    // Watchdog runs only while the owner's strobe waits on the slave
    assign wd_wait   = (state == OWN) && s0_cyc && s0_stb && !s0_ack && !s0_err;
    assign wd_expire = (TIMEOUT != 0) && wd_wait && (wd_cnt == TMO_M1);

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: release on CYC drop takes priority over a watchdog abort
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pick_any) state_nxt = OWN;
            OWN: begin
                if (!m_cyc[gnt])    state_nxt = IDLE;
                else if (wd_expire) state_nxt = ABORT;
            end
            ABORT:   if (!m_cyc[gnt]) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Grant, round-robin history, watchdog counter and abort pulse flag
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            gnt         <= '0;
            last        <= GNT_W'(N_ARB_MASTERS - 1);
            wd_cnt      <= '0;
            abort_first <= 1'b0;
        end else begin
            if (state == IDLE && pick_any) begin
                gnt <= pick_idx;
            end
            if (state != IDLE && state_nxt == IDLE) begin
                last <= gnt;
            end
            if (!wd_wait) begin
                wd_cnt <= '0;
            end else if (wd_cnt != CNT_SAT) begin
                wd_cnt <= wd_cnt + 1'b1;
            end
            abort_first <= (state == OWN) && (state_nxt == ABORT);
        end
    end

    // Slave-side mux: owner's signals in OWN, all zero otherwise
    always_comb begin
        s0_cyc   = 1'b0;
        s0_stb   = 1'b0;
        s0_we    = 1'b0;
        s0_adr   = '0;
        s0_dat_w = '0;
        s0_sel   = '0;
        s0_cti   = '0;
        s0_bte   = '0;
        if (state == OWN) begin
            s0_cyc   = m_cyc[gnt];
            s0_stb   = m_stb[gnt];
            s0_we    = m_we[gnt];
            s0_adr   = m_adr_a[gnt];
            s0_dat_w = m_dat_w_a[gnt];
            s0_sel   = m_sel_a[gnt];
            s0_cti   = m_cti_a[gnt];
            s0_bte   = m_bte_a[gnt];
        end
    end

    // Master-side responses: only the owner sees ACK/ERR
    always_comb begin
        m_ack = '0;
        m_err = '0;
        for (int i = 0; i < N_ARB_MASTERS; i++) begin
            if (gnt == GNT_W'(i)) begin
                m_ack[i] = (state == OWN) && s0_ack;
                m_err[i] = ((state == OWN) && s0_err) || abort_first;
            end
        end
    end

    assign m_dat_r     = s0_dat_r;
    assign gnt_vld     = (state != IDLE);
    assign timeout_evt = abort_first;

endmodule
`default_nettype wire

// File: tb/tb_wb_arbiter_4x1_rr.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_arbiter_4x1_rr
// Description : Directed self-checking bench for wb_arbiter_4x1_rr.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_arbiter_4x1_rr;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int SW  = DW / 8;
    localparam int TMO = 8;

    logic clk  = 1'b0;
    logic rstn = 1'b1;

    logic [3:0]      m_cyc, m_stb, m_we, m_ack, m_err;
    logic [4*AW-1:0] m_adr;
    logic [4*DW-1:0] m_dat_w;
    logic [4*SW-1:0] m_sel;
    logic [11:0]     m_cti;
    logic [7:0]      m_bte;
    logic [DW-1:0]   m_dat_r;
    logic            s0_cyc, s0_stb, s0_we, s0_ack, s0_err;
    logic [AW-1:0]   s0_adr;
    logic [DW-1:0]   s0_dat_w, s0_dat_r;
    logic [SW-1:0]   s0_sel;
    logic [2:0]      s0_cti;
    logic [1:0]      s0_bte;
    logic [1:0]      gnt;
    logic            gnt_vld, timeout_evt;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    wb_arbiter_4x1_rr #(
        .WB_ADDR_WIDTH (AW),
        .WB_DATA_WIDTH (DW),
        .TIMEOUT       (TMO)
    ) dut (
        .clk (clk), .rstn (rstn),
        .m_cyc (m_cyc), .m_stb (m_stb), .m_we (m_we), .m_adr (m_adr),
        .m_dat_w (m_dat_w), .m_sel (m_sel), .m_cti (m_cti), .m_bte (m_bte),
        .m_ack (m_ack), .m_err (m_err), .m_dat_r (m_dat_r),
        .s0_cyc (s0_cyc), .s0_stb (s0_stb), .s0_we (s0_we), .s0_adr (s0_adr),
        .s0_dat_w (s0_dat_w), .s0_sel (s0_sel), .s0_cti (s0_cti), .s0_bte (s0_bte),
        .s0_ack (s0_ack), .s0_err (s0_err), .s0_dat_r (s0_dat_r),
        .gnt (gnt), .gnt_vld (gnt_vld), .timeout_evt (timeout_evt)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        m_cyc = '0; m_stb = '0; m_we = '0; m_adr = '0; m_dat_w = '0;
        m_sel = '0; m_cti = '0; m_bte = '0;
        s0_ack = 1'b0; s0_err = 1'b0; s0_dat_r = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rstn = 1'b0;
        step();
        step();
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        clear_inputs();
        #1 rstn = 1'b0;
        #2;
        if ({gnt, gnt_vld, timeout_evt} !== 4'b0) begin
            $display("FAIL reset_status: got gnt=%0d vld=%0b evt=%0b, expected 0/0/0", gnt, gnt_vld, timeout_evt);
            miscompares++;
        end
        vectors++;
        if ({s0_cyc, s0_stb, s0_we, s0_adr, s0_dat_w, s0_sel, s0_cti, s0_bte} !== '0) begin
            $display("FAIL reset_s0: got cyc=%0b stb=%0b adr=%h, expected all zero", s0_cyc, s0_stb, s0_adr);
            miscompares++;
        end
        vectors++;
        if ({m_ack, m_err} !== 8'h00) begin
            $display("FAIL reset_m_resp: got ack=%b err=%b, expected 0000/0000", m_ack, m_err);
            miscompares++;
        end
        vectors++;
        step();
        step();
        rstn = 1'b1;
    endtask

    task automatic test_single();
        m_adr[1*AW +: AW] = 32'h100;
        m_sel[1*SW +: SW] = 4'hF;
        m_cyc[1] = 1'b1; m_stb[1] = 1'b1;
        #1;
        if (gnt_vld !== 1'b0) begin
            $display("FAIL single_latency: got gnt_vld=%0b, expected 0", gnt_vld);
            miscompares++;
        end
        vectors++;
        step();
        if (gnt !== 2'd1 || gnt_vld !== 1'b1 || s0_cyc !== 1'b1 || s0_adr !== 32'h100) begin
            $display("FAIL single_grant: got gnt=%0d vld=%0b cyc=%0b adr=%h, expected 1/1/1/100", gnt, gnt_vld, s0_cyc, s0_adr);
            miscompares++;
        end
        vectors++;
        step();
        s0_ack = 1'b1; s0_dat_r = 32'hCAFE_0100;
        #1;
        if (m_ack !== 4'b0010 || m_dat_r !== 32'hCAFE_0100) begin
            $display("FAIL single_ack: got ack=%b dat=%h, expected 0010/cafe0100", m_ack, m_dat_r);
            miscompares++;
        end
        vectors++;
        step();
        s0_ack = 1'b0; m_cyc[1] = 1'b0; m_stb[1] = 1'b0;
        #1;
        if (m_ack !== 4'b0000 || s0_cyc !== 1'b0) begin
            $display("FAIL single_release: got ack=%b cyc=%0b, expected 0000/0", m_ack, s0_cyc);
            miscompares++;
        end
        vectors++;
        step();
        if (gnt_vld !== 1'b0) begin
            $display("FAIL single_idle: got gnt_vld=%0b, expected 0", gnt_vld);
            miscompares++;
        end
        vectors++;
    endtask

    task automatic test_round_robin();
        int order [5] = '{0, 1, 2, 3, 0};
        int o;
        do_reset();
        for (int i = 0; i < 4; i++) m_adr[i*AW +: AW] = 32'h1000 * (i + 1);
        m_cyc = 4'hF; m_stb = 4'hF;
        for (int i = 0; i < 5; i++) begin
            o = order[i];
            step();
            if (gnt_vld !== 1'b1 || gnt !== 2'(o) || s0_adr !== 32'(32'h1000 * (o + 1))) begin
                $display("FAIL rr_grant%0d: got gnt=%0d vld=%0b adr=%h, expected gnt=%0d", i, gnt, gnt_vld, s0_adr, o);
                miscompares++;
            end
            vectors++;
            s0_ack = 1'b1;
            #1;
            if (m_ack !== (4'b0001 << o)) begin
                $display("FAIL rr_ack%0d: got %b, expected %b", i, m_ack, 4'b0001 << o);
                miscompares++;
            end
            vectors++;
            step();
            s0_ack = 1'b0; m_cyc[o] = 1'b0; m_stb[o] = 1'b0;
            step();
            if (gnt_vld !== 1'b0) begin
                $display("FAIL rr_dead%0d: got gnt_vld=%0b, expected 0", i, gnt_vld);
                miscompares++;
            end
            vectors++;
            if (i == 0) begin
                m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
            end
        end
    endtask

    task automatic test_burst();
        m_adr[2*AW +: AW] = 32'h200; m_cti[2*3 +: 3] = 3'b010;
        m_cyc[2] = 1'b1; m_stb[2] = 1'b1; m_we[2] = 1'b1;
        step();
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
        for (int b = 0; b < 4; b++) begin
            m_adr[2*AW +: AW]   = 32'h200 + 32'(4 * b);
            m_cti[2*3 +: 3]     = (b == 3) ? 3'b111 : 3'b010;
            m_dat_w[2*DW +: DW] = 32'hD0 + 32'(b);
            s0_ack = 1'b1;
            #1;
            if (gnt !== 2'd2 || s0_cyc !== 1'b1 || s0_adr !== 32'h200 + 32'(4 * b)
                || s0_cti !== ((b == 3) ? 3'b111 : 3'b010) || s0_dat_w !== 32'hD0 + 32'(b)
                || s0_we !== 1'b1 || m_ack !== 4'b0100) begin
                $display("FAIL burst_beat%0d: got gnt=%0d cyc=%0b adr=%h cti=%b ack=%b", b, gnt, s0_cyc, s0_adr, s0_cti, m_ack);
                miscompares++;
            end
            vectors++;
            step();
        end
        s0_ack = 1'b0; m_cyc[2] = 1'b0; m_stb[2] = 1'b0; m_we[2] = 1'b0;
        #1;
        if (gnt_vld !== 1'b1 || gnt !== 2'd2) begin
            $display("FAIL burst_hold: got gnt=%0d vld=%0b, expected 2/1", gnt, gnt_vld);
            miscompares++;
        end
        vectors++;
        step();
        if (gnt_vld !== 1'b0) begin
            $display("FAIL burst_dead: got gnt_vld=%0b, expected 0", gnt_vld);
            miscompares++;
        end
        vectors++;
        step();
        if (gnt_vld !== 1'b1 || gnt !== 2'd0) begin
            $display("FAIL burst_next: got gnt=%0d vld=%0b, expected 0/1", gnt, gnt_vld);
            miscompares++;
        end
        vectors++;
        m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
        step();
    endtask

    task automatic test_timeout();
        m_adr[3*AW +: AW] = 32'h300;
        m_cyc[3] = 1'b1; m_stb[3] = 1'b1;
        step();
        for (int w = 1; w <= TMO; w++) begin
            #1;
            if (m_err !== 4'b0000 || timeout_evt !== 1'b0 || s0_cyc !== 1'b1) begin
                $display("FAIL tmo_wait%0d: got err=%b evt=%0b cyc=%0b, expected 0000/0/1", w, m_err, timeout_evt, s0_cyc);
                miscompares++;
            end
            vectors++;
            step();
        end
        if (m_err !== 4'b1000 || timeout_evt !== 1'b1 || s0_cyc !== 1'b0 || s0_stb !== 1'b0) begin
            $display("FAIL tmo_abort: got err=%b evt=%0b cyc=%0b, expected 1000/1/0", m_err, timeout_evt, s0_cyc);
            miscompares++;
        end
        vectors++;
        step();
        if (m_err !== 4'b0000 || timeout_evt !== 1'b0 || s0_cyc !== 1'b0 || gnt_vld !== 1'b1) begin
            $display("FAIL tmo_after: got err=%b evt=%0b cyc=%0b vld=%0b, expected 0000/0/0/1", m_err, timeout_evt, s0_cyc, gnt_vld);
            miscompares++;
        end
        vectors++;
        m_cyc[3] = 1'b0; m_stb[3] = 1'b0;
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
        step();
        if (gnt_vld !== 1'b0) begin
            $display("FAIL tmo_idle: got gnt_vld=%0b, expected 0", gnt_vld);
            miscompares++;
        end
        vectors++;
        step();
        if (gnt_vld !== 1'b1 || gnt !== 2'd0 || s0_cyc !== 1'b1) begin
            $display("FAIL tmo_regrant: got gnt=%0d vld=%0b cyc=%0b, expected 0/1/1", gnt, gnt_vld, s0_cyc);
            miscompares++;
        end
        vectors++;
        m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
        step();
    endtask

    task automatic test_boundary();
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
        step();
        for (int w = 1; w < TMO; w++) step();
        s0_ack = 1'b1; s0_dat_r = 32'h0000_B0B0;
        #1;
        if (m_ack !== 4'b0001 || m_err !== 4'b0000 || timeout_evt !== 1'b0) begin
            $display("FAIL bound_ack: got ack=%b err=%b evt=%0b, expected 0001/0000/0", m_ack, m_err, timeout_evt);
            miscompares++;
        end
        vectors++;
        step();
        s0_ack = 1'b0;
        #1;
        if (m_err !== 4'b0000 || timeout_evt !== 1'b0 || s0_cyc !== 1'b1 || gnt_vld !== 1'b1) begin
            $display("FAIL bound_noabort: got err=%b evt=%0b cyc=%0b, expected 0000/0/1", m_err, timeout_evt, s0_cyc);
            miscompares++;
        end
        vectors++;
        m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
        step();
    endtask

    task automatic test_reset_mid();
        m_adr[1*AW +: AW] = 32'h500; m_cti[1*3 +: 3] = 3'b010;
        m_cyc[1] = 1'b1; m_stb[1] = 1'b1;
        step();
        s0_ack = 1'b1;
        #1;
        if (m_ack !== 4'b0010) begin
            $display("FAIL rmid_beat1: got ack=%b, expected 0010", m_ack);
            miscompares++;
        end
        vectors++;
        step();
        m_adr[1*AW +: AW] = 32'h504;
        #1 rstn = 1'b0;
        #1;
        if (gnt_vld !== 1'b0 || gnt !== 2'd0 || s0_cyc !== 1'b0 || s0_adr !== '0
            || m_ack !== 4'b0000 || timeout_evt !== 1'b0) begin
            $display("FAIL rmid_async: got vld=%0b gnt=%0d cyc=%0b adr=%h ack=%b", gnt_vld, gnt, s0_cyc, s0_adr, m_ack);
            miscompares++;
        end
        vectors++;
        clear_inputs();
        rstn = 1'b1;
        m_cyc = 4'b1011; m_stb = 4'b1011;
        step();
        if (gnt_vld !== 1'b1 || gnt !== 2'd0) begin
            $display("FAIL rmid_first: got gnt=%0d vld=%0b, expected 0/1", gnt, gnt_vld);
            miscompares++;
        end
        vectors++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_burst();
        test_timeout();
        test_boundary();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
